// File: rtl/bullet_hit_detector.sv
// Scans the snake segment list against two latched bullet cells and reports the first hit.
// Optional HIT_COOLDOWN_EN: ignore the 8 scan_tick pulses that follow a hit.
module bullet_hit_detector #(
  parameter int GRID_W  = 40,
  parameter int GRID_H  = 30,
  parameter int MAX_LEN = 64,
  parameter int LIVES   = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         scan_tick,
  input  logic                         game_over,
  input  logic [9:0]                   b0_px,
  input  logic [9:0]                   b0_py,
  input  logic [9:0]                   b1_px,
  input  logic [9:0]                   b1_py,
  input  logic                         b0_active,
  input  logic                         b1_active,
  input  logic [$clog2(MAX_LEN):0]     snake_len,
  output logic [$clog2(MAX_LEN)-1:0]   seg_addr,
  input  logic [$clog2(GRID_W)-1:0]    seg_x,
  input  logic [$clog2(GRID_H)-1:0]    seg_y,
  output logic                         hit,
  output logic                         hit_src,
  output logic [$clog2(MAX_LEN)-1:0]   hit_seg,
  output logic                         kill_b0,
  output logic                         kill_b1,
  output logic [1:0]                   lives,
  output logic                         lives_zero,
  output logic                         busy
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int LW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HIT   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          cmp_vld_q, cmp_vld_d;
  logic [AW-1:0] cmp_idx_q, cmp_idx_d;
  logic [5:0]    b0x_q, b0x_d, b0y_q, b0y_d, b1x_q, b1x_d, b1y_q, b1y_d;
  logic          b0v_q, b0v_d, b1v_q, b1v_d;
  logic          hit_q, hit_d, src_q, src_d, k0_q, k0_d, k1_q, k1_d;
  logic [AW-1:0] hseg_q, hseg_d;
  logic [1:0]    lives_q, lives_d;
`ifdef HIT_COOLDOWN_EN
  logic [3:0]    cd_q, cd_d;
`endif

  logic [5:0] g0x, g0y, g1x, g1y;
  logic       in0, in1, m0, m1, start_ok, last_addr;
  logic       unused_pix;

  assign g0x = b0_px[9:4];
  assign g0y = b0_py[9:4];
  assign g1x = b1_px[9:4];
  assign g1y = b1_py[9:4];
  assign unused_pix = ^{b0_px[3:0], b0_py[3:0], b1_px[3:0], b1_py[3:0]};

  // Off-playfield bullets are latched as inactive so they can never match.
  assign in0 = b0_active && (32'(g0x) < GRID_W) && (32'(g0y) < GRID_H);
  assign in1 = b1_active && (32'(g1x) < GRID_W) && (32'(g1y) < GRID_H);

  assign m0 = cmp_vld_q && b0v_q && (16'(seg_x) == 16'(b0x_q)) && (16'(seg_y) == 16'(b0y_q));
  assign m1 = cmp_vld_q && b1v_q && (16'(seg_x) == 16'(b1x_q)) && (16'(seg_y) == 16'(b1y_q));

  assign last_addr = ({1'b0, addr_q} == (snake_len - LW'(1)));
  assign start_ok  = scan_tick && !game_over && (snake_len != '0) && (b0_active || b1_active);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cmp_vld_d = 1'b0;
    cmp_idx_d = cmp_idx_q;
    b0x_d = b0x_q;  b0y_d = b0y_q;  b0v_d = b0v_q;
    b1x_d = b1x_q;  b1y_d = b1y_q;  b1v_d = b1v_q;
    hit_d  = 1'b0;
    k0_d   = 1'b0;
    k1_d   = 1'b0;
    src_d  = src_q;
    hseg_d = hseg_q;
    lives_d = lives_q;
`ifdef HIT_COOLDOWN_EN
    cd_d = cd_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef HIT_COOLDOWN_EN
        if (scan_tick && !game_over && (cd_q != 4'd0)) begin
          cd_d = cd_q - 4'd1;
        end else
`endif
        if (start_ok) begin
          state_d = S_SCAN;
          addr_d  = '0;
          b0x_d = g0x;  b0y_d = g0y;  b0v_d = in0;
          b1x_d = g1x;  b1y_d = g1y;  b1v_d = in1;
        end
      end
      S_SCAN, S_DRAIN: begin
        if (m0 || m1) begin
          state_d = S_HIT;
          hit_d   = 1'b1;
          src_d   = !m0;
          hseg_d  = cmp_idx_q;
          k0_d    = m0;
          k1_d    = !m0;
          lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
`ifdef HIT_COOLDOWN_EN
          cd_d    = 4'd8;
`endif
        end else if (state_q == S_DRAIN) begin
          state_d = S_IDLE;
        end else begin
          // The address issued now returns next cycle, so it becomes the compare index.
          cmp_vld_d = 1'b1;
          cmp_idx_d = addr_q;
          if (last_addr) state_d = S_DRAIN;
          else           addr_d  = addr_q + AW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (game_over) begin
      state_d   = S_IDLE;
      cmp_vld_d = 1'b0;
      hit_d     = 1'b0;
      k0_d      = 1'b0;
      k1_d      = 1'b0;
      src_d     = src_q;
      hseg_d    = hseg_q;
      lives_d   = lives_q;
`ifdef HIT_COOLDOWN_EN
      cd_d      = 4'd0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      cmp_vld_q <= 1'b0;
      cmp_idx_q <= '0;
      b0x_q <= '0;  b0y_q <= '0;  b0v_q <= 1'b0;
      b1x_q <= '0;  b1y_q <= '0;  b1v_q <= 1'b0;
      hit_q  <= 1'b0;
      src_q  <= 1'b0;
      hseg_q <= '0;
      k0_q   <= 1'b0;
      k1_q   <= 1'b0;
      lives_q <= 2'(LIVES);
`ifdef HIT_COOLDOWN_EN
      cd_q   <= 4'd0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cmp_vld_q <= cmp_vld_d;
      cmp_idx_q <= cmp_idx_d;
      b0x_q <= b0x_d;  b0y_q <= b0y_d;  b0v_q <= b0v_d;
      b1x_q <= b1x_d;  b1y_q <= b1y_d;  b1v_q <= b1v_d;
      hit_q  <= hit_d;
      src_q  <= src_d;
      hseg_q <= hseg_d;
      k0_q   <= k0_d;
      k1_q   <= k1_d;
      lives_q <= lives_d;
`ifdef HIT_COOLDOWN_EN
      cd_q   <= cd_d;
`endif
    end
  end

  assign seg_addr   = addr_q;
  assign hit        = hit_q;
  assign hit_src    = src_q;
  assign hit_seg    = hseg_q;
  assign kill_b0    = k0_q;
  assign kill_b1    = k1_q;
  assign lives      = lives_q;
  assign lives_zero = (lives_q == 2'd0);
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_bullet_hit_detector.sv
// Directed and randomized scans of bullet_hit_detector against a first-match reference model.
module tb_bullet_hit_detector;
  localparam int GW = 40, GH = 30, ML = 64, LV = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, scan_tick, game_over, b0_active, b1_active;
  logic [9:0] b0_px, b0_py, b1_px, b1_py;
  logic [6:0] snake_len;
  logic [5:0] seg_addr, hit_seg, seg_x;
  logic [4:0] seg_y;
  logic hit, hit_src, kill_b0, kill_b1, lives_zero, busy;
  logic [1:0] lives;

  bullet_hit_detector #(.GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML), .LIVES(LV)) dut (
    .clk(clk), .rst(rst), .scan_tick(scan_tick), .game_over(game_over),
    .b0_px(b0_px), .b0_py(b0_py), .b1_px(b1_px), .b1_py(b1_py),
    .b0_active(b0_active), .b1_active(b1_active), .snake_len(snake_len),
    .seg_addr(seg_addr), .seg_x(seg_x), .seg_y(seg_y), .hit(hit), .hit_src(hit_src),
    .hit_seg(hit_seg), .kill_b0(kill_b0), .kill_b1(kill_b1), .lives(lives),
    .lives_zero(lives_zero), .busy(busy)
  );

  // Segment store with one-cycle read latency.
  logic [5:0] mx[ML];
  logic [4:0] my[ML];
  always @(posedge clk) begin
    seg_x <= mx[seg_addr];
    seg_y <= my[seg_addr];
  end

  int ncmp = 0, nfail = 0, exp_lives = LV;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  function automatic bit cell_match(int px, int py, bit act, int k);
    int gx = px / 16, gy = py / 16;
    return act && gx < GW && gy < GH && gx == int'(mx[k]) && gy == int'(my[k]);
  endfunction

  // First segment (in head-to-tail order) hit by either bullet; b0 wins ties.
  task automatic ref_scan(output int idx, output int src);
    idx = -1; src = 0;
    for (int k = 0; k < int'(snake_len); k++) begin
      if (cell_match(b0_px, b0_py, b0_active, k)) begin idx = k; src = 0; return; end
      if (cell_match(b1_px, b1_py, b1_active, k)) begin idx = k; src = 1; return; end
    end
  endtask

  task automatic fill_default();
    for (int k = 0; k < ML; k++) begin
      mx[k] = 6'(k % 40);
      my[k] = 5'(k / 40);
    end
  endtask

  task automatic set_b(int p0x, int p0y, bit a0, int p1x, int p1y, bit a1);
    b0_px = 10'(p0x); b0_py = 10'(p0y); b0_active = a0;
    b1_px = 10'(p1x); b1_py = 10'(p1y); b1_active = a1;
  endtask

  task automatic scan(output int hc, output int ic, output logic src,
                      output logic [5:0] hs, output logic k0, output logic k1);
    scan_tick = 1'b1;
    @(negedge clk);
    scan_tick = 1'b0;
    hc = -1; ic = -1; src = 1'bx; hs = 'x; k0 = 1'bx; k1 = 1'bx;
    for (int c = 1; c <= 140; c++) begin
      if (hit && hc < 0) begin hc = c; src = hit_src; hs = hit_seg; k0 = kill_b0; k1 = kill_b1; end
      if (!busy) begin ic = c; break; end
      @(negedge clk);
    end
  endtask

  task automatic after_hit(input string tag);
`ifdef HIT_COOLDOWN_EN
    for (int i = 0; i < 8; i++) begin
      scan_tick = 1'b1;
      @(negedge clk);
      scan_tick = 1'b0;
      @(negedge clk);
      chk({tag, "_cool_busy"}, 32'(busy), 0);
      chk({tag, "_cool_hit"}, 32'(hit), 0);
    end
`else
    chk({tag, "_idle"}, 32'(busy), 0);
`endif
  endtask

  task automatic run_check(input string tag);
    int ei, es, hc, ic;
    logic src, k0, k1;
    logic [5:0] hs;
    ref_scan(ei, es);
    scan(hc, ic, src, hs, k0, k1);
    if (ei >= 0) begin
      exp_lives = (exp_lives > 0) ? exp_lives - 1 : 0;
      chk({tag, "_hitcyc"}, 32'(hc), 32'(ei + 3));
      chk({tag, "_src"}, 32'(src), 32'(es));
      chk({tag, "_seg"}, 32'(hs), 32'(ei));
      chk({tag, "_kill0"}, 32'(k0), 32'(es == 0));
      chk({tag, "_kill1"}, 32'(k1), 32'(es == 1));
      chk({tag, "_idlecyc"}, 32'(ic), 32'(ei + 4));
    end else begin
      chk({tag, "_nohit"}, 32'(hc), 32'(-1));
      chk({tag, "_idlecyc"}, 32'(ic), 32'(int'(snake_len) + 2));
    end
    chk({tag, "_lives"}, 32'(lives), 32'(exp_lives));
    chk({tag, "_lz"}, 32'(lives_zero), 32'(exp_lives == 0));
    if (ei >= 0) after_hit(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_lives = LV;
  endtask

  initial begin
    int t;
    rst = 1'b1; scan_tick = 1'b0; game_over = 1'b0; snake_len = 7'd0;
    set_b(0, 0, 0, 0, 0, 0);
    fill_default();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_lives", 32'(lives), LV);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_hit", 32'(hit), 0);
    chk("rst_addr", 32'(seg_addr), 0);
    chk("rst_kill", 32'({kill_b0, kill_b1}), 0);
    chk("rst_lz", 32'(lives_zero), 0);

    // Hit on segment 2, five cycles after scan_tick.
    snake_len = 7'd5; mx[2] = 6'd10; my[2] = 5'd12;
    set_b(165, 197, 1, 600, 470, 0);
    run_check("seg2");

    // Both bullets in the head cell: b0 wins, then b1 on the next scan.
    fill_default();
    set_b(3, 5, 1, 10, 14, 1);
    run_check("tie");
    set_b(3, 5, 0, 10, 14, 1);
    run_check("tie_b1");

    // Full-length miss.
    snake_len = 7'd64;
    set_b(100, 400, 1, 500, 450, 1);
    run_check("miss64");

    // Off-playfield cells never match, the last in-range cell does.
    fill_default(); snake_len = 7'd3;
    mx[0] = 6'd40; my[0] = 5'd0; mx[1] = 6'd5; my[1] = 5'd30;
    set_b(640, 0, 1, 80, 480, 1);
    run_check("offgrid");
    mx[2] = 6'd39; my[2] = 5'd29;
    set_b(639, 479, 1, 80, 480, 1);
    run_check("edge_cell");

    // Lives count down and saturate.
    do_reset();
    fill_default(); snake_len = 7'd5; mx[2] = 6'd10; my[2] = 5'd12;
    set_b(165, 197, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) run_check($sformatf("lives%0d", i));

    // game_over mid-scan aborts before the segment-5 match.
    fill_default(); snake_len = 7'd8; mx[5] = 6'd20; my[5] = 5'd20;
    set_b(325, 330, 1, 0, 0, 0);
    t = exp_lives;
    scan_tick = 1'b1;
    @(negedge clk);
    scan_tick = 1'b0;
    for (int c = 0; c < 10 && seg_addr != 6'd3; c++) @(negedge clk);
    chk("go_addr3", 32'(seg_addr), 3);
    game_over = 1'b1;
    @(negedge clk);
    game_over = 1'b0;
    chk("go_busy", 32'(busy), 0);
    chk("go_hit", 32'(hit), 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (hit || kill_b0) chk("go_late_hit", 32'({hit, kill_b0}), 0);
    end
    chk("go_lives", 32'(lives), 32'(t));
    set_b(325, 330, 0, 0, 0, 0);
    scan_tick = 1'b1;
    @(negedge clk);
    scan_tick = 1'b0;
    chk("noact_busy", 32'(busy), 0);
    @(negedge clk);
    chk("noact_busy2", 32'(busy), 0);

    // Reset in the middle of a scan.
    do_reset();
    snake_len = 7'd5; fill_default(); mx[2] = 6'd10; my[2] = 5'd12;
    set_b(165, 197, 1, 0, 0, 0);
    scan_tick = 1'b1;
    @(negedge clk);
    scan_tick = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_hit", 32'(hit), 0);
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_lives", 32'(lives), LV);
    @(negedge clk);
    chk("rstmid_hit2", 32'(hit), 0);

    // Randomized snakes and bullets.
    for (int r = 0; r < 24; r++) begin
      int k0, k1;
      if (r % 6 == 0) do_reset();
      snake_len = 7'($urandom_range(1, 64));
      for (int k = 0; k < ML; k++) begin
        mx[k] = 6'($urandom_range(0, GW - 1));
        my[k] = 5'($urandom_range(0, GH - 1));
      end
      k0 = $urandom_range(0, int'(snake_len) - 1);
      k1 = $urandom_range(0, int'(snake_len) - 1);
      set_b(($urandom_range(0, 1) != 0) ? int'(mx[k0]) * 16 + $urandom_range(0, 15) : $urandom_range(0, 1023),
            ($urandom_range(0, 1) != 0) ? int'(my[k0]) * 16 + $urandom_range(0, 15) : $urandom_range(0, 1023),
            1'($urandom_range(0, 3) != 0),
            int'(mx[k1]) * 16 + $urandom_range(0, 15),
            ($urandom_range(0, 1) != 0) ? int'(my[k1]) * 16 + $urandom_range(0, 15) : $urandom_range(0, 1023),
            1'($urandom_range(0, 1)));
      if (!b0_active && !b1_active) b1_active = 1'b1;
      run_check($sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
